cp0_regfile: RTL and testbench

- Architectural CP0 register file, the write-side endpoint of the CP0 data path.
- Committed mtc0 writes arrive from WB. Exception and ERET commits arrive from the commit stage.
- Provides an uncached combinational read port. Stage forwarding of in-flight mtc0 writes is handled outside this block.
- Owns Count/Compare timer, interrupt pending/masking and exception-state update (EPC, Cause, Status.EXL, BadVAddr).

---
 rtl/cp0_regfile.sv | 152 +++++++++++++++
 tb/tb_cp0_regfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 architectural register file: Count/Compare timer, interrupt
// masking and exception-state update, with a combinational read port.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        exc_badva_valid,
  input  logic [31:0] exc_badva,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_req,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [31:0] ST_MASK = 32'h0000_FF03;

  logic [DW-1:0] r_div;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic [31:0]   r_status;
  logic [31:0]   r_epc;
  logic [31:0]   r_badva;
  logic          r_ti;
  logic          r_bd;
  logic [4:0]    r_exccode;
  logic [1:0]    r_ip_sw;
  logic [5:0]    r_hw;

  logic          w_wr;
  logic          w_wr_count;
  logic          w_wr_compare;
  logic          w_wr_status;
  logic          w_wr_cause;
  logic          w_wr_epc;
  logic          w_wrap;
  logic [31:0]   w_count_inc;
  logic [31:0]   w_status_mtc;
  logic [31:0]   w_cause;

  // An exception commit swallows any same-cycle mtc0.
  assign w_wr         = we & ~exc_valid & (wsel == 3'd0);
  assign w_wr_count   = w_wr & (waddr == 5'd9);
  assign w_wr_compare = w_wr & (waddr == 5'd11);
  assign w_wr_status  = w_wr & (waddr == 5'd12);
  assign w_wr_cause   = w_wr & (waddr == 5'd13);
  assign w_wr_epc     = w_wr & (waddr == 5'd14);

  assign w_wrap      = (r_div == DW'(COUNT_DIV - 1));
  assign w_count_inc = r_count + 32'd1;

  assign w_status_mtc = w_wr_status
    ? ((r_status & ~ST_MASK) | (wdata & ST_MASK))
    : r_status;

  assign w_cause = {r_bd, r_ti, 14'd0,
                    r_hw[5] | r_ti, r_hw[4:0],
                    r_ip_sw, 1'b0, r_exccode, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= wdata;
        r_div   <= '0;
      end else begin
        r_div <= w_wrap ? '0 : r_div + 1'b1;
        if (w_wrap) r_count <= w_count_inc;
      end
      // Compare write clears TI even if an increment matches now.
      if (w_wr_compare) begin
        r_compare <= wdata;
        r_ti      <= 1'b0;
      end else if (!w_wr_count && w_wrap &&
                   w_count_inc == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status  <= STATUS_RST;
      r_epc     <= '0;
      r_badva   <= '0;
      r_bd      <= 1'b0;
      r_exccode <= '0;
      r_ip_sw   <= '0;
      r_hw      <= '0;
    end else begin
      r_hw <= hw_int;
      if (exc_valid) begin
        r_exccode <= exc_code;
        if (!r_status[1]) begin
          r_epc <= exc_epc;
          r_bd  <= exc_bd;
        end
        r_status <= r_status | 32'h0000_0002;
        if (exc_badva_valid) r_badva <= exc_badva;
      end else begin
        r_status <= eret ? (w_status_mtc & ~32'h0000_0002)
                         : w_status_mtc;
        if (w_wr_cause) r_ip_sw <= wdata[9:8];
        if (w_wr_epc)   r_epc   <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        5'd8:    rdata = r_badva;
        5'd9:    rdata = r_count;
        5'd11:   rdata = r_compare;
        5'd12:   rdata = r_status;
        5'd13:   rdata = w_cause;
        5'd14:   rdata = r_epc;
        default: rdata = '0;
      endcase
    end
  end

  assign int_req = r_status[0] & ~r_status[1] &
                   (|(w_cause[15:8] & r_status[15:8]));

  assign status_o  = r_status;
  assign cause_o   = w_cause;
  assign epc_o     = r_epc;
  assign timer_int = r_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios, then random traffic
// checked against an arithmetic reference model.
module tb_cp0_regfile;

  localparam int DIV = 2;
  localparam logic [31:0] ST_RST = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        exc_badva_valid;
  logic [31:0] exc_badva;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_req;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int;

  always #10 clk = ~clk;

  cp0_regfile #(.STATUS_RST(ST_RST), .COUNT_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wsel(wsel), .wdata(wdata), .raddr(raddr), .rsel(rsel),
    .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badva_valid(exc_badva_valid), .exc_badva(exc_badva),
    .eret(eret), .hw_int(hw_int), .int_req(int_req),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int(timer_int)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: Count is base value plus elapsed cycles / DIV.
  logic [31:0] m_base;
  int          m_cyc;
  logic [31:0] m_compare;
  logic        m_ti;
  logic [31:0] m_status;
  logic [1:0]  m_sw;
  logic        m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [31:0] m_badva;
  logic [5:0]  m_hwq;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / DIV);
  endfunction

  function automatic logic [31:0] m_cause();
    logic [7:0] ip;
    ip = {m_hwq[5] | m_ti, m_hwq[4:0], m_sw};
    return {m_bd, m_ti, 14'd0, ip, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && !m_status[1] &&
           ((c[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  task automatic mstep();
    logic wr;
    logic old_exl;
    logic [31:0] nc;
    if (!rst_n) begin
      m_base = 0; m_cyc = 0; m_compare = 0; m_ti = 0;
      m_status = ST_RST; m_sw = 0; m_bd = 0; m_code = 0;
      m_epc = 0; m_badva = 0; m_hwq = 0;
      return;
    end
    wr = we && !exc_valid && wsel == 3'd0;
    old_exl = m_status[1];
    if (wr && waddr == 5'd9) begin
      m_base = wdata;
      m_cyc  = 0;
    end else begin
      m_cyc = m_cyc + 1;
      nc = m_count();
      if ((m_cyc % DIV) == 0 && nc == m_compare) m_ti = 1;
    end
    if (wr && waddr == 5'd11) begin
      m_compare = wdata;
      m_ti = 0;
    end
    if (exc_valid) begin
      m_code = exc_code;
      if (!old_exl) begin
        m_epc = exc_epc;
        m_bd  = exc_bd;
      end
      m_status[1] = 1'b1;
      if (exc_badva_valid) m_badva = exc_badva;
    end else begin
      if (wr && waddr == 5'd12)
        m_status = (m_status & ~32'hFF03) | (wdata & 32'hFF03);
      if (wr && waddr == 5'd13) m_sw = wdata[9:8];
      if (wr && waddr == 5'd14) m_epc = wdata;
      if (eret) m_status[1] = 1'b0;
    end
    m_hwq = hw_int;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s,
                    output logic [31:0] v);
    raddr = a;
    rsel  = s;
    #1;
    v = rdata;
  endtask

  task automatic check_all();
    logic [31:0] v;
    rd(5'd8, 3'd0, v);  chk("badva", v, m_badva);
    rd(5'd9, 3'd0, v);  chk("count", v, m_count());
    rd(5'd11, 3'd0, v); chk("compare", v, m_compare);
    rd(5'd12, 3'd0, v); chk("status_rd", v, m_status);
    rd(5'd13, 3'd0, v); chk("cause_rd", v, m_cause());
    rd(5'd14, 3'd0, v); chk("epc_rd", v, m_epc);
    rd(5'd14, 3'd1, v); chk("unimpl_sel", v, 32'd0);
    rd(5'd0, 3'd0, v);  chk("unimpl_reg", v, 32'd0);
    chk("status_o", status_o, m_status);
    chk("cause_o", cause_o, m_cause());
    chk("epc_o", epc_o, m_epc);
    chk("timer_int", 32'(timer_int), 32'(m_ti));
    chk("int_req", 32'(int_req), 32'(m_int()));
  endtask

  task automatic tick();
    mstep();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    we = 0;
    exc_valid = 0;
    eret = 0;
    exc_badva_valid = 0;
  endtask

  task automatic mtc(input logic [4:0] a, input logic [2:0] s,
                     input logic [31:0] d);
    we = 1; waddr = a; wsel = s; wdata = d;
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  addrs [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
    rst_n = 0; we = 0; waddr = 0; wsel = 0; wdata = 0;
    raddr = 0; rsel = 0; exc_valid = 0; exc_code = 0;
    exc_epc = 0; exc_bd = 0; exc_badva_valid = 0;
    exc_badva = 0; eret = 0; hw_int = 0;

    tick();
    tick();
    rst_n = 1;
    chk("rst_status", status_o, 32'h0040_0000);
    rd(5'd9, 3'd0, v);
    chk("rst_count", v, 32'd0);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_intreq", 32'(int_req), 32'd0);

    mtc(5'd11, 3'd0, 32'd5);
    tick();
    idle();
    repeat (9) tick();
    rd(5'd9, 3'd0, v);
    chk("count_at_10", v, 32'd5);
    chk("ti_set", 32'(timer_int), 32'd1);
    chk("cause_ip7", 32'(cause_o[15]), 32'd1);

    mtc(5'd12, 3'd0, 32'h0000_8001);
    tick();
    idle();
    chk("status_masked", status_o, 32'h0040_8001);
    chk("intreq_on", 32'(int_req), 32'd1);

    exc_valid = 1; exc_code = 5'd0;
    exc_epc = 32'hBFC0_0100; exc_bd = 0;
    tick();
    idle();
    chk("exl_set", 32'(status_o[1]), 32'd1);
    chk("intreq_masked", 32'(int_req), 32'd0);
    chk("epc_exc", epc_o, 32'hBFC0_0100);

    exc_valid = 1; exc_code = 5'd4; exc_epc = 32'h8000_0200;
    exc_badva_valid = 1; exc_badva = 32'h1234_5679;
    tick();
    idle();
    chk("nest_code", 32'(cause_o[6:2]), 32'd4);
    rd(5'd8, 3'd0, v);
    chk("nest_badva", v, 32'h1234_5679);
    chk("nest_epc", epc_o, 32'hBFC0_0100);

    eret = 1;
    tick();
    idle();
    chk("eret_exl", 32'(status_o[1]), 32'd0);
    chk("eret_intreq", 32'(int_req), 32'd1);

    mtc(5'd11, 3'd0, 32'd9);
    tick();
    idle();
    chk("ti_clear", 32'(timer_int), 32'd0);

    mtc(5'd14, 3'd0, 32'hDEAD_BEEF);
    exc_valid = 1; exc_code = 5'd0; exc_epc = 32'h8000_0010;
    tick();
    idle();
    chk("exc_over_mtc", epc_o, 32'h8000_0010);
    eret = 1;
    tick();
    idle();

    mtc(5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    rd(5'd9, 3'd0, v);
    chk("count_load", v, 32'hFFFF_FFFF);
    repeat (DIV) tick();
    rd(5'd9, 3'd0, v);
    chk("count_wrap", v, 32'd0);

    mtc(5'd3, 3'd0, 32'hFFFF_FFFF);
    tick();
    mtc(5'd12, 3'd1, 32'hFFFF_FFFF);
    tick();
    idle();
    rd(5'd3, 3'd0, v);
    chk("reg3_zero", v, 32'd0);
    rd(5'd12, 3'd1, v);
    chk("reg12s1_zero", v, 32'd0);
    chk("status_kept", status_o, 32'h0040_8001);

    repeat (500) begin
      rst_n = ($urandom_range(0, 99) != 0);
      exc_valid = ($urandom_range(0, 7) == 0);
      eret = ($urandom_range(0, 7) == 0);
      we = 1'($urandom_range(0, 1));
      waddr = addrs[$urandom_range(0, 7)];
      wsel = ($urandom_range(0, 5) == 0)
             ? 3'($urandom_range(1, 7)) : 3'd0;
      if (waddr == 5'd11)
        wdata = m_count() + 32'($urandom_range(0, 6));
      else if (waddr == 5'd9)
        wdata = m_compare - 32'($urandom_range(0, 4));
      else
        wdata = $urandom;
      exc_code = 5'($urandom);
      exc_epc = $urandom;
      exc_bd = 1'($urandom);
      exc_badva_valid = 1'($urandom);
      exc_badva = $urandom;
      hw_int = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
      tick();
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
